// File: rtl/mem_master.sv
// mem_master: converts one byte/half/word load or store into an aligned word-bus
// transaction with byte enables, then returns the extracted read data as a
// one-cycle response pulse.
// Optional feature macro MEM_MASTER_TIMEOUT_EN: abort a transaction after
// `timeout` stalled cycles and report it as an error.
module mem_master #(
  parameter int unsigned addr_w  = 32,
  parameter int unsigned data_w  = 32,
  parameter int unsigned timeout = 16
) (
  input  logic              gclk,
  input  logic              resetn,
  input  logic              req,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [addr_w-1:0] req_addr,
  input  logic [data_w-1:0] req_wdata,
  output logic              resp_valid,
  output logic [data_w-1:0] resp_rdata,
  output logic              resp_error,
  output logic [addr_w-1:0] mem_addr,
  input  logic [data_w-1:0] mem_rdata,
  output logic [data_w-1:0] mem_wdata,
  output logic [3:0]        mem_b_en,
  output logic              mem_w_en,
  input  logic              mem_stall,
  input  logic              mem_error
);

  localparam logic [1:0] sz_byte = 2'b00;
  localparam logic [1:0] sz_half = 2'b01;
  localparam logic [1:0] sz_word = 2'b10;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t            state, state_n;
  logic [1:0]        off_q, off_n;
  logic              write_q, write_n;
  logic [1:0]        size_q, size_n;
  logic              sgn_q, sgn_n;
  logic [addr_w-1:0] addr_n;
  logic [data_w-1:0] wdata_n;
  logic [3:0]        be_n;
  logic              wen_n;
  logic              err_n;

  logic              misaligned_c;
  logic [3:0]        lane_be_c;
  logic [data_w-1:0] lane_wdata_c;
  logic [data_w-1:0] shifted_c;
  logic [data_w-1:0] ext_c;

`ifdef MEM_MASTER_TIMEOUT_EN
  localparam int unsigned cnt_w = (timeout < 1) ? 1 : $clog2(timeout + 1);
  logic [cnt_w-1:0] stall_cnt, stall_cnt_n;
`else
  logic unused_cfg;
  assign unused_cfg = ^32'(timeout);
`endif

  // Handshake/status decodes of the state register.
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  // Alignment check, byte enables and lane replication for the incoming request.
  always_comb begin
    misaligned_c = 1'b0;
    lane_be_c    = 4'b1111;
    lane_wdata_c = req_wdata;
    case (req_size)
      sz_byte: begin
        lane_be_c    = 4'b0001 << req_addr[1:0];
        lane_wdata_c = {4{req_wdata[7:0]}};
      end
      sz_half: begin
        misaligned_c = req_addr[0];
        lane_be_c    = req_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata_c = {2{req_wdata[15:0]}};
      end
      sz_word: misaligned_c = (req_addr[1:0] != 2'b00);
      default: misaligned_c = 1'b1;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_n = state;
    off_n   = off_q;
    write_n = write_q;
    size_n  = size_q;
    sgn_n   = sgn_q;
    addr_n  = mem_addr;
    wdata_n = mem_wdata;
    be_n    = mem_b_en;
    wen_n   = mem_w_en;
    err_n   = resp_error;
`ifdef MEM_MASTER_TIMEOUT_EN
    stall_cnt_n = stall_cnt;
`endif
    case (state)
      IDLE: begin
        err_n = 1'b0;
        if (req) begin
          off_n   = req_addr[1:0];
          write_n = req_write;
          size_n  = req_size;
          sgn_n   = req_signed;
          if (misaligned_c) begin
            state_n = RESP;
            err_n   = 1'b1;
          end else begin
            state_n = REQ;
            addr_n  = {req_addr[addr_w-1:2], 2'b00};
            wdata_n = lane_wdata_c;
            be_n    = lane_be_c;
            wen_n   = req_write;
`ifdef MEM_MASTER_TIMEOUT_EN
            stall_cnt_n = '0;
`endif
          end
        end
      end
      REQ: begin
        if (!mem_stall) begin
          state_n = RESP;
          err_n   = mem_error;
          addr_n  = '0;
          wdata_n = '0;
          be_n    = 4'b0000;
          wen_n   = 1'b0;
        end
`ifdef MEM_MASTER_TIMEOUT_EN
        else if (stall_cnt == cnt_w'(timeout)) begin
          state_n = RESP;
          err_n   = 1'b1;
          addr_n  = '0;
          wdata_n = '0;
          be_n    = 4'b0000;
          wen_n   = 1'b0;
        end else begin
          stall_cnt_n = stall_cnt + cnt_w'(1);
        end
`endif
      end
      RESP: begin
        state_n = IDLE;
        err_n   = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge gclk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      off_q      <= 2'b00;
      write_q    <= 1'b0;
      size_q     <= 2'b00;
      sgn_q      <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_b_en   <= 4'b0000;
      mem_w_en   <= 1'b0;
      resp_error <= 1'b0;
`ifdef MEM_MASTER_TIMEOUT_EN
      stall_cnt  <= '0;
`endif
    end else begin
      state      <= state_n;
      off_q      <= off_n;
      write_q    <= write_n;
      size_q     <= size_n;
      sgn_q      <= sgn_n;
      mem_addr   <= addr_n;
      mem_wdata  <= wdata_n;
      mem_b_en   <= be_n;
      mem_w_en   <= wen_n;
      resp_error <= err_n;
`ifdef MEM_MASTER_TIMEOUT_EN
      stall_cnt  <= stall_cnt_n;
`endif
    end
  end

  // Load data extraction; the responder's registered data is only valid in RESP.
  always_comb begin
    shifted_c = mem_rdata >> {off_q, 3'b000};
    case (size_q)
      sz_byte: ext_c = {{(data_w-8){sgn_q & shifted_c[7]}}, shifted_c[7:0]};
      sz_half: ext_c = {{(data_w-16){sgn_q & shifted_c[15]}}, shifted_c[15:0]};
      default: ext_c = shifted_c;
    endcase
    resp_rdata = (resp_valid && !write_q && !resp_error) ? ext_c : '0;
  end

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master with a small byte-enabled SRAM responder model.
module tb_mem_master;

  logic        gclk = 1'b0;
  logic        resetn;
  logic        req;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_b_en;
  logic        mem_w_en;
  logic        mem_stall;
  logic        mem_error;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 gclk = ~gclk;

  mem_master #(.addr_w(32), .data_w(32), .timeout(4)) dut (
    .gclk(gclk), .resetn(resetn),
    .req(req), .req_ready(req_ready), .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
    .mem_b_en(mem_b_en), .mem_w_en(mem_w_en), .mem_stall(mem_stall), .mem_error(mem_error)
  );

  // Responder: 4 KiB word memory, registered read, error outside the window.
  logic [31:0] ram [0:1023];
  assign mem_error = (mem_addr[31:12] != 20'h0);
  always @(posedge gclk) begin
    if (mem_b_en != 4'b0000 && !mem_stall && !mem_error) begin
      if (mem_w_en) begin
        for (int b = 0; b < 4; b++)
          if (mem_b_en[b]) ram[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= ram[mem_addr[11:2]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One request; lat = cycles from the sampling edge to the response pulse.
  task automatic txn(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                     input logic [31:0] ad, input logic [31:0] wd, input int stall, input int lat,
                     input logic [3:0] exp_be, input logic [31:0] exp_wd, input logic exp_err,
                     input logic rd_chk, input logic [31:0] exp_rd);
    @(negedge gclk);
    chk({tag, " ready_before"}, 32'(req_ready), 32'd1);
    req = 1'b1; req_write = wr; req_size = sz; req_signed = sg; req_addr = ad; req_wdata = wd;
    @(posedge gclk);
    @(negedge gclk);
    req = 1'b0;
    for (int k = 0; k < lat; k++) begin
      if (k < lat - 1) begin
        chk({tag, " b_en"}, 32'(mem_b_en), 32'(exp_be));
        chk({tag, " addr"}, mem_addr, {ad[31:2], 2'b00});
        chk({tag, " w_en"}, 32'(mem_w_en), 32'(wr));
        if (wr) chk({tag, " wdata"}, mem_wdata, exp_wd);
        chk({tag, " valid_early"}, 32'(resp_valid), 32'd0);
        chk({tag, " ready_busy"}, 32'(req_ready), 32'd0);
        mem_stall = (k < stall);
      end else begin
        chk({tag, " valid"}, 32'(resp_valid), 32'd1);
        chk({tag, " error"}, 32'(resp_error), 32'(exp_err));
        chk({tag, " b_en_resp"}, 32'(mem_b_en), 32'd0);
        if (rd_chk) chk({tag, " rdata"}, resp_rdata, exp_rd);
        mem_stall = 1'b0;
      end
      @(negedge gclk);
    end
    chk({tag, " valid_after"}, 32'(resp_valid), 32'd0);
    chk({tag, " ready_after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    resetn = 1'b0; req = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_stall = 1'b0;
    #23;
    chk("rst ready", 32'(req_ready), 32'd1);
    chk("rst valid", 32'(resp_valid), 32'd0);
    chk("rst error", 32'(resp_error), 32'd0);
    chk("rst rdata", resp_rdata, 32'h0);
    chk("rst addr", mem_addr, 32'h0);
    chk("rst wdata", mem_wdata, 32'h0);
    chk("rst b_en", 32'(mem_b_en), 32'd0);
    chk("rst w_en", 32'(mem_w_en), 32'd0);
    @(negedge gclk);
    resetn = 1'b1;

    //  tag            wr    sz     sg    addr          wdata        st lat be       exp_wd        err  rd   exp_rd
    txn("st_w40",      1'b1, 2'b10, 1'b0, 32'h40,       32'hDEADBEEF, 0, 2, 4'b1111, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0);
    txn("ld_w40",      1'b0, 2'b10, 1'b0, 32'h40,       32'h0,        0, 2, 4'b1111, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF);
    txn("st_b103",     1'b1, 2'b00, 1'b0, 32'h103,      32'h123456A5, 0, 2, 4'b1000, 32'hA5A5A5A5, 1'b0, 1'b1, 32'h0);
    txn("ld_sb103",    1'b0, 2'b00, 1'b1, 32'h103,      32'h0,        0, 2, 4'b1000, 32'h0,        1'b0, 1'b1, 32'hFFFFFFA5);
    txn("ld_ub103",    1'b0, 2'b00, 1'b0, 32'h103,      32'h0,        0, 2, 4'b1000, 32'h0,        1'b0, 1'b1, 32'h000000A5);
    txn("st_w100",     1'b1, 2'b10, 1'b0, 32'h100,      32'h80011234, 0, 2, 4'b1111, 32'h80011234, 1'b0, 1'b1, 32'h0);
    txn("ld_sh102",    1'b0, 2'b01, 1'b1, 32'h102,      32'h0,        0, 2, 4'b1100, 32'h0,        1'b0, 1'b1, 32'hFFFF8001);
    txn("ld_uh102",    1'b0, 2'b01, 1'b0, 32'h102,      32'h0,        0, 2, 4'b1100, 32'h0,        1'b0, 1'b1, 32'h00008001);
    txn("ld_ub101",    1'b0, 2'b00, 1'b0, 32'h101,      32'h0,        0, 2, 4'b0010, 32'h0,        1'b0, 1'b1, 32'h00000012);
    txn("st_h200",     1'b1, 2'b01, 1'b0, 32'h200,      32'h7777BEEF, 0, 2, 4'b0011, 32'hBEEFBEEF, 1'b0, 1'b1, 32'h0);
    txn("ld_sh200",    1'b0, 2'b01, 1'b1, 32'h200,      32'h0,        0, 2, 4'b0011, 32'h0,        1'b0, 1'b1, 32'hFFFFBEEF);
    txn("mis_h101",    1'b0, 2'b01, 1'b0, 32'h101,      32'h0,        0, 1, 4'b0000, 32'h0,        1'b1, 1'b0, 32'h0);
    txn("mis_w102",    1'b1, 2'b10, 1'b0, 32'h102,      32'h11223344, 0, 1, 4'b0000, 32'h0,        1'b1, 1'b0, 32'h0);
    txn("mis_sz3",     1'b0, 2'b11, 1'b0, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        1'b1, 1'b0, 32'h0);
    txn("ld_oor",      1'b0, 2'b10, 1'b0, 32'h00010000, 32'h0,        0, 2, 4'b1111, 32'h0,        1'b1, 1'b0, 32'h0);
    txn("ld_stall3",   1'b0, 2'b10, 1'b0, 32'h40,       32'h0,        3, 5, 4'b1111, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF);
`ifdef MEM_MASTER_TIMEOUT_EN
    txn("ld_tmo",      1'b0, 2'b10, 1'b0, 32'h40,       32'h0,       10, 6, 4'b1111, 32'h0,        1'b1, 1'b1, 32'h0);
`else
    txn("ld_stall10",  1'b0, 2'b10, 1'b0, 32'h40,       32'h0,       10, 12, 4'b1111, 32'h0,       1'b0, 1'b1, 32'hDEADBEEF);
`endif

    // Reset during the bus phase of a store aborts it silently.
    @(negedge gclk);
    req = 1'b1; req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h80; req_wdata = 32'hCAFEF00D;
    @(posedge gclk);
    @(negedge gclk);
    req = 1'b0;
    chk("abort b_en_req", 32'(mem_b_en), 32'hF);
    resetn = 1'b0;
    #1;
    chk("abort b_en", 32'(mem_b_en), 32'd0);
    chk("abort w_en", 32'(mem_w_en), 32'd0);
    chk("abort addr", mem_addr, 32'h0);
    chk("abort wdata", mem_wdata, 32'h0);
    chk("abort valid", 32'(resp_valid), 32'd0);
    chk("abort ready", 32'(req_ready), 32'd1);
    @(negedge gclk);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge gclk);
      chk("abort no_valid", 32'(resp_valid), 32'd0);
      chk("abort ready_rel", 32'(req_ready), 32'd1);
    end

    txn("ld_after_rst", 1'b0, 2'b10, 1'b0, 32'h100,     32'h0,        0, 2, 4'b1111, 32'h0,        1'b0, 1'b1, 32'h80011234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_master.md
# mem_master

Bus initiator that sits between the core's load/store logic and a word-organised memory with byte enables (the `sram` responder). Accepts one byte/half/word load or store request at a time, converts it into an aligned word-bus transaction (aligned address, byte enables, write enable, lane-replicated write data), honours stall, then returns the extracted and extended read data or write completion, with error status, as a one-cycle response pulse.

## Interface
Parameters:
- `addr_w`, 32, address width.
- `data_w`, 32, bus data width; only 32 is supported.
- `timeout`, 16, stall cycles tolerated before abort (used only under `MEM_MASTER_TIMEOUT_EN`).

Ports:
- `gclk`  in  1  global clock; all state updates on rising edge.
- `resetn`  in  1  asynchronous active-low reset.
- `req`  in  1  request strobe; sampled only when `req_ready`=1.
- `req_ready`  out  1  high in IDLE only.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 reserved.
- `req_signed`  in  1  sign-extend load result.
- `req_addr`  in  addr_w  byte address.
- `req_wdata`  in  data_w  store data, right-justified.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  data_w  extracted, extended load data; 0 for stores.
- `resp_error`  out  1  valid with `resp_valid`: misaligned, bus error, or timeout.
- `mem_addr`  out  addr_w  word-aligned address, `{req_addr[addr_w-1:2],2'b00}`.
- `mem_rdata`  in  data_w  responder read data, registered by responder.
- `mem_wdata`  out  data_w  lane-replicated store data.
- `mem_b_en`  out  4  byte enables.
- `mem_w_en`  out  1  write enable.
- `mem_stall`  in  1  responder stall.
- `mem_error`  in  1  responder error (combinational on address).

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE: `req`=1 latches all request fields. Aligned request -> REQ. Misaligned request (half with addr[0]=1, word with addr[1:0]≠0, or size 11) -> RESP with error set, no bus activity.
- REQ: drives `mem_addr`, `mem_b_en`, `mem_w_en`, `mem_wdata` from registers. `mem_stall`=1 -> stay, all bus outputs held. `mem_stall`=0 -> sample `mem_error` into error flag, go to RESP.
- RESP: bus outputs 0. `resp_valid`=1. For loads, `resp_rdata` = (`mem_rdata` >> 8·addr[1:0]) truncated to size, then zero- or sign-extended per `req_signed`. Next state IDLE.
- Byte enables: byte `4'b0001 << addr[1:0]`; half `4'b0011` (addr[1]=0) or `4'b1100`; word `4'b1111`.
- Write data: byte replicated ×4, half ×2, word unchanged.
- Loads assert `mem_b_en` with `mem_w_en`=0; stores assert both.
- `req` while not in IDLE is ignored; no queueing.

## Timing
- Reset: state IDLE; `req_ready`=1; `resp_valid`, `resp_error`, `resp_rdata`, `mem_addr`, `mem_wdata`, `mem_b_en`, `mem_w_en` all 0.
- `req` sampled at edge E0 -> REQ during cycle E0..E1 -> RESP during E1..E2 (`resp_valid` high) -> IDLE. Unstalled latency 2 cycles; each stall cycle adds 1.
- Misaligned: E0 -> RESP directly; latency 1, `mem_b_en` never nonzero.
- Load data is used in RESP, one cycle after the responder samples the address.
- Throughput: at most one request per 3 cycles, or per 2 for misaligned.
- Reset asserted in any state: immediate return to IDLE with reset outputs. The aborted request produces no `resp_valid`.

## Configuration
- `MEM_MASTER_TIMEOUT_EN` defined: a stall counter clears on entry to REQ and increments on each stalled REQ cycle. When it reaches `timeout`, go to RESP with `resp_error`=1 and `resp_rdata`=0, and drop bus outputs.
- Undefined: no counter. REQ waits indefinitely on `mem_stall`.

## Test plan
- Word store 0xDEADBEEF at 0x40, then word load at 0x40 -> `mem_b_en`=1111, `mem_w_en`=1, `resp_valid` 2 cycles after each `req`. Load returns 0xDEADBEEF, `resp_error`=0.
- Byte store 0xA5 at 0x103 -> `mem_addr`=0x100, `mem_b_en`=1000, `mem_wdata`=0xA5A5A5A5. Signed byte load at 0x103 -> 0xFFFFFFA5. Unsigned byte load -> 0x000000A5.
- Half load at 0x102, memory word 0x8001_1234 -> signed 0xFFFF8001, unsigned 0x00008001, `mem_b_en`=1100.
- Half load at 0x101 -> `resp_valid` and `resp_error` 1 cycle after `req`, `mem_b_en` stays 0. Load at an out-of-range address -> `resp_error`=1.
- `mem_stall` held 3 cycles during REQ -> bus outputs stable, `resp_valid` at cycle 5. With the macro and `timeout`=4, stall held 10 cycles -> `resp_error`=1 at cycle 6.
- `resetn` pulsed low during REQ of a store -> outputs 0 immediately, no `resp_valid`, `req_ready`=1 after release.
